// File: rtl/stego_stream_ctrl.sv
// stego_stream_ctrl: serial fetch / embed / write sequencer shared by all colour channels.
// Rev 1.0
`default_nettype none

module stego_stream_ctrl #(
    parameter int NUM_PIXELS = 3072,
    parameter int NUM_TEXT   = 2976,
    parameter int NUM_KEY    = 208,
    parameter int AW         = 12,
    parameter int KAW        = 8
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           start_i,
    input  logic           mode_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           rd_en_o,
    output logic [AW-1:0]  img_addr_o,
    output logic [AW-1:0]  txt_addr_o,
    output logic [KAW-1:0] key_addr_o,
    input  logic [7:0]     img_data_i,
    input  logic [3:0]     txt_data_i,
    input  logic [3:0]     key_data_i,
    output logic           out_we_o,
    output logic [AW-1:0]  out_addr_o,
    output logic [7:0]     out_data_o,
    input  logic           out_ready_i
);

    localparam logic [AW-1:0]  C_LAST_PIX = AW'(NUM_PIXELS - 1);
    localparam logic [AW-1:0]  C_NUM_TEXT = AW'(NUM_TEXT);
    localparam logic [KAW-1:0] C_LAST_KEY = KAW'(NUM_KEY - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state_q;
    logic [AW-1:0]  pix_cnt_q;
    logic [KAW-1:0] key_cnt_q;
    logic           mode_q;
    logic           busy_q;
    logic           done_q;
    logic           rd_en_q;
    logic           out_we_q;
    logic [7:0]     out_data_q;

    logic           passthru_d;
    logic [3:0]     nib_d;
    logic [7:0]     emb_byte_d;
    logic [2:0]     unused_nib;

    // Mode 1 is the encrypt-then-decrypt round trip, which collapses back to the text nibble.
    assign passthru_d = (pix_cnt_q >= C_NUM_TEXT);
    assign nib_d      = mode_q ? txt_data_i : (txt_data_i ^ key_data_i);
    assign emb_byte_d = passthru_d ? img_data_i : {img_data_i[7:3], nib_d[0], 2'b00};
    assign unused_nib = nib_d[3:1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            pix_cnt_q  <= '0;
            key_cnt_q  <= '0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            out_we_q   <= 1'b0;
            out_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        pix_cnt_q <= '0;
                        key_cnt_q <= '0;
                        mode_q    <= mode_i;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        state_q   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Memory data is valid now; the output byte register doubles as the holding register.
                    out_data_q <= emb_byte_d;
                    out_we_q   <= 1'b1;
                    state_q    <= S_WRITE;
                end
                S_WRITE: begin
                    if (out_ready_i) begin
                        out_we_q <= 1'b0;
                        if (pix_cnt_q == C_LAST_PIX) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + 1'b1;
                            if (!passthru_d) begin
                                key_cnt_q <= (key_cnt_q == C_LAST_KEY) ? '0 : key_cnt_q + 1'b1;
                            end
                            rd_en_q <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rd_en_o    = rd_en_q;
    assign img_addr_o = pix_cnt_q;
    assign txt_addr_o = pix_cnt_q;
    assign key_addr_o = key_cnt_q;
    assign out_we_o   = out_we_q;
    assign out_addr_o = pix_cnt_q;
    assign out_data_o = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_stego_stream_ctrl.sv
// tb_stego_stream_ctrl: directed table-driven bench for stego_stream_ctrl (8 pixels, 5 text, 3 key).
// Rev 1.0
`default_nettype none

module tb_stego_stream_ctrl;

    localparam int NP  = 8;
    localparam int NT  = 5;
    localparam int NK  = 3;
    localparam int AW  = 12;
    localparam int KAW = 8;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           start_i;
    logic           mode_i;
    logic           busy_o;
    logic           done_o;
    logic           rd_en_o;
    logic [AW-1:0]  img_addr_o;
    logic [AW-1:0]  txt_addr_o;
    logic [KAW-1:0] key_addr_o;
    logic [7:0]     img_data_i;
    logic [3:0]     txt_data_i;
    logic [3:0]     key_data_i;
    logic           out_we_o;
    logic [AW-1:0]  out_addr_o;
    logic [7:0]     out_data_o;
    logic           out_ready_i;

    stego_stream_ctrl #(
        .NUM_PIXELS(NP), .NUM_TEXT(NT), .NUM_KEY(NK), .AW(AW), .KAW(KAW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
        .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
        .img_addr_o(img_addr_o), .txt_addr_o(txt_addr_o), .key_addr_o(key_addr_o),
        .img_data_i(img_data_i), .txt_data_i(txt_data_i), .key_data_i(key_data_i),
        .out_we_o(out_we_o), .out_addr_o(out_addr_o), .out_data_o(out_data_o),
        .out_ready_i(out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] img_mem [0:7];
    logic [3:0] txt_mem [0:7];
    logic [3:0] key_mem [0:3];

    always @(posedge clk_i) begin
        if (rd_en_o) begin
            img_data_i <= img_mem[img_addr_o[2:0]];
            txt_data_i <= txt_mem[txt_addr_o[2:0]];
            key_data_i <= key_mem[key_addr_o[1:0]];
        end
    end

    typedef struct {
        int              img_kind;    // 0: 0xFF, 1: 0x10+i, 2: 0x07
        logic [3:0]      txt;
        logic [3:0]      key;
        logic            mode;
        int              stall_pix;
        int              stall_len;
        bit              start_pulse; // extra start pulses while busy and in DONE
        logic [7:0][7:0] exp;         // exp[i] = expected byte for pixel i
    } vec_t;

    vec_t vecs [8];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_mems(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            img_mem[i] = (v.img_kind == 0) ? 8'hFF : (v.img_kind == 1) ? 8'(8'h10 + i) : 8'h07;
            txt_mem[i] = v.txt;
        end
        for (int i = 0; i < 4; i++) key_mem[i] = v.key;
    endtask

    task automatic run_vec(input int idx);
        vec_t         v;
        int           cyc;
        int           stall;
        int           nwr;
        int           nk;
        int           done_cyc;
        bit           got_done;
        int           kmod;
        logic [AW-1:0]  wa [8];
        logic [7:0]     wd [8];
        logic [KAW-1:0] ks [8];
        v = vecs[idx];
        load_mems(v);
        @(posedge clk_i); #1;
        chk($sformatf("v%0d idle_busy", idx), 32'(busy_o), 32'd0);
        chk($sformatf("v%0d idle_rd_en", idx), 32'(rd_en_o), 32'd0);
        mode_i      = v.mode;
        start_i     = 1'b1;
        out_ready_i = 1'b1;
        cyc = 0; stall = 0; nwr = 0; nk = 0; done_cyc = 0; got_done = 1'b0;
        while (!got_done && cyc < 200) begin
            @(posedge clk_i); #1;
            cyc++;
            if (cyc == 1) begin
                start_i = 1'b0;
                mode_i  = ~v.mode;
            end
            if (v.start_pulse && cyc == 10) start_i = 1'b1;
            if (v.start_pulse && cyc == 11) start_i = 1'b0;
            if (rd_en_o) begin
                if (nk < 8) ks[nk] = key_addr_o;
                nk++;
            end
            if (out_we_o) begin
                if (32'(out_addr_o) == v.stall_pix && stall < v.stall_len) begin
                    chk($sformatf("v%0d stall%0d_addr", idx, stall), 32'(out_addr_o), 32'(v.stall_pix));
                    chk($sformatf("v%0d stall%0d_data", idx, stall), 32'(out_data_o), 32'(v.exp[v.stall_pix]));
                    out_ready_i = 1'b0;
                    stall++;
                end else begin
                    out_ready_i = 1'b1;
                    if (nwr < 8) begin
                        wa[nwr] = out_addr_o;
                        wd[nwr] = out_data_o;
                    end
                    nwr++;
                end
            end else begin
                out_ready_i = 1'b1;
            end
            if (done_o) begin
                got_done = 1'b1;
                done_cyc = cyc;
                if (v.start_pulse) start_i = 1'b1;
            end
        end
        if (!got_done) begin
            n_tests++;
            n_fail++;
            $display("FAIL v%0d timeout: got no done expected done by cycle %0d", idx, 25 + v.stall_len);
            start_i = 1'b0;
            return;
        end
        chk($sformatf("v%0d done_cycle", idx), 32'(done_cyc), 32'(25 + v.stall_len));
        chk($sformatf("v%0d busy_in_done", idx), 32'(busy_o), 32'd1);
        chk($sformatf("v%0d write_count", idx), 32'(nwr), 32'd8);
        chk($sformatf("v%0d fetch_count", idx), 32'(nk), 32'd8);
        kmod = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < nwr) begin
                chk($sformatf("v%0d out_addr[%0d]", idx, i), 32'(wa[i]), 32'(i));
                chk($sformatf("v%0d out_data[%0d]", idx, i), 32'(wd[i]), 32'(v.exp[i]));
            end
            if (i < nk) chk($sformatf("v%0d key_addr[%0d]", idx, i), 32'(ks[i]), 32'(kmod));
            if (i < NT) kmod = (kmod == NK - 1) ? 0 : kmod + 1;
        end
        if (!v.start_pulse) start_i = 1'b0;
    endtask

    initial begin
        int  guard;
        bit  saw_done;
        bit  saw_we;
        vecs[0] = '{0, 4'h1, 4'h1, 1'b0, 99, 0, 1'b0,
                    {8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'hF8, 8'hF8, 8'hF8, 8'hF8}};
        vecs[1] = '{0, 4'h1, 4'h1, 1'b1, 99, 0, 1'b0,
                    {8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC}};
        vecs[2] = '{0, 4'h1, 4'h0, 1'b0, 99, 0, 1'b0,
                    {8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC}};
        vecs[3] = '{1, 4'h1, 4'h1, 1'b0, 99, 0, 1'b0,
                    {8'h17, 8'h16, 8'h15, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10}};
        vecs[4] = '{1, 4'h6, 4'h3, 1'b0, 99, 0, 1'b0,
                    {8'h17, 8'h16, 8'h15, 8'h14, 8'h14, 8'h14, 8'h14, 8'h14}};
        vecs[5] = '{1, 4'h6, 4'h3, 1'b1, 2, 4, 1'b0,
                    {8'h17, 8'h16, 8'h15, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10}};
        vecs[6] = '{2, 4'h1, 4'h0, 1'b0, 99, 0, 1'b1,
                    {8'h07, 8'h07, 8'h07, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04}};
        vecs[7] = '{0, 4'h0, 4'h1, 1'b1, 99, 0, 1'b0,
                    {8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'hF8, 8'hF8, 8'hF8, 8'hF8}};

        reset_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; out_ready_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        chk("rst busy",     32'(busy_o),     32'd0);
        chk("rst done",     32'(done_o),     32'd0);
        chk("rst rd_en",    32'(rd_en_o),    32'd0);
        chk("rst out_we",   32'(out_we_o),   32'd0);
        chk("rst addrs",    32'({img_addr_o, txt_addr_o, key_addr_o}), 32'd0);
        chk("rst out_addr", 32'(out_addr_o), 32'd0);
        chk("rst out_data", 32'(out_data_o), 32'd0);
        reset_i = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i);

        // Abort a run with reset during WAIT of pixel 3.
        @(posedge clk_i); #1;
        load_mems(vecs[0]);
        mode_i  = 1'b0;
        start_i = 1'b1;
        guard   = 0;
        do begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            guard++;
        end while (!(rd_en_o && img_addr_o == 12'd3) && guard < 60);
        chk("abort reached_fetch3", 32'(img_addr_o), 32'd3);
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        #1;
        chk("abort busy",     32'(busy_o),     32'd0);
        chk("abort out_we",   32'(out_we_o),   32'd0);
        chk("abort rd_en",    32'(rd_en_o),    32'd0);
        chk("abort out_addr", 32'(out_addr_o), 32'd0);
        chk("abort key_addr", 32'(key_addr_o), 32'd0);
        chk("abort out_data", 32'(out_data_o), 32'd0);
        @(posedge clk_i); #1;
        reset_i  = 1'b0;
        saw_done = 1'b0;
        saw_we   = 1'b0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (done_o)   saw_done = 1'b1;
            if (out_we_o) saw_we   = 1'b1;
        end
        chk("abort no_done",  32'(saw_done), 32'd0);
        chk("abort no_write", 32'(saw_we),   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
